serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor: computes D = A - B, one bit per clock, LSB first, using a 1-bit full-subtractor cell and a borrow flip-flop.
- This is the inverse-direction companion to the team's combinational full adder. It is used where area matters more than latency; results feed the lab's display/ALU datapath.
- Uses a START/BUSY/DONE handshake.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - state_e       : 2-bit FSM state encoding (IDLE / SHIFT / DONE)
//   - WIDTH_DEFAULT : default operand/result width
package serial_subtractor_pkg;

   localparam int WIDTH_DEFAULT = 8;

   // Prefixed so the enum literals do not collide with the DONE port name.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   1-bit combinational full subtractor: X - Y - BIN.
//   Ports:
//     X    : minuend bit
//     Y    : subtrahend bit
//     BIN  : borrow in
//     DIFF : difference bit
//     BOUT : borrow out
module full_subtractor (
   input  logic X,
   input  logic Y,
   input  logic BIN,
   output logic DIFF,
   output logic BOUT
);

   assign DIFF = X ^ Y ^ BIN;
   // Borrow when X=0,Y=1, or when X==Y and a borrow is already pending.
   assign BOUT = (~X & Y) | (~(X ^ Y) & BIN);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor, D = A - B, LSB first, one bit per clock,
//   with a START/BUSY/DONE handshake.
//   Parameters:
//     WIDTH : operand/result width (>= 2)
//   Ports:
//     CLK   : clock, rising edge
//     RST   : asynchronous active-high reset
//     START : request, sampled only in IDLE
//     A, B  : operands, captured on the accepting edge
//     BUSY  : high while bits are being processed
//     DONE  : one-cycle pulse, D/BOUT valid
//     D     : difference mod 2^WIDTH (held until the next accepting edge)
//     BOUT  : final borrow, 1 when A < B
//     OVF   : signed overflow of A - B (only with SERIAL_SUBTRACTOR_OVF_EN)
//   Build option:
//     SERIAL_SUBTRACTOR_OVF_EN : adds the OVF output and its logic.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] D,
   output logic             BOUT
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,output logic             OVF
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             fs_diff, fs_bout;
   logic             last_bit;

   // Single serial cell working on the current LSBs.
   full_subtractor u_fs (
      .X    (a_q[0]),
      .Y    (b_q[0]),
      .BIN  (borrow_q),
      .DIFF (fs_diff),
      .BOUT (fs_bout)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (START)    state_d = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      BUSY = 1'b0;
      DONE = 1'b0;
      case (state_q)
         ST_SHIFT: BUSY = 1'b1;
         ST_DONE:  DONE = 1'b1;
         default: ;
      endcase
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      d_d      = d_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               a_d      = A;
               b_d      = B;
               borrow_d = 1'b0;
               cnt_d    = '0;
            end
         end
         ST_SHIFT: begin
            // New bit enters at the MSB; after WIDTH shifts the result is LSB-aligned.
            d_d      = {fs_diff, d_q[WIDTH-1:1]};
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            borrow_d = fs_bout;
            cnt_d    = cnt_q + CW'(1);
            if (last_bit) bout_d = fs_bout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         d_q      <= d_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
      end
   end

   assign D    = d_q;
   assign BOUT = bout_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic ovf_q, ovf_d;

   // On the last bit a_q[0]/b_q[0] are the operand MSBs and fs_diff the result MSB.
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == ST_SHIFT && last_bit)
         ovf_d = (a_q[0] != b_q[0]) && (fs_diff != a_q[0]);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench: directed vector table, random operands against an
//   arithmetic reference model, and hand-written handshake/abort sequences.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         BUSY, DONE, BOUT;
   logic [W-1:0] D;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         OVF;
`endif

   int n_vec = 0;
   int n_bad = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .D     (D),
      .BOUT  (BOUT)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
     ,.OVF   (OVF)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_d;
      logic         exp_bout;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic.
   function automatic logic [W-1:0] ref_d(input logic [W-1:0] a, input logic [W-1:0] b);
      int r;
      r = (int'(a) - int'(b) + (1 << W)) % (1 << W);
      return W'(r);
   endfunction

   function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b);
      return int'(a) < int'(b);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb, r;
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      r  = sa - sb;
      return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
   endfunction

   // Full operation with cycle-accurate handshake checks.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d, input logic exp_bout);
      logic ok;
      @(negedge CLK);
      A = a; B = b; START = 1'b1;
      @(negedge CLK);               // edge 0 has been taken
      START = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (BUSY !== 1'b1 || DONE !== 1'b0) ok = 1'b0;
         @(negedge CLK);
      end
      chk({tag, " busy window"}, 32'(ok), 32'd1);
      chk({tag, " done"}, 32'({DONE, BUSY}), 32'b10);
      chk({tag, " D"}, 32'(D), 32'(exp_d));
      chk({tag, " BOUT"}, 32'(BOUT), 32'(exp_bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk({tag, " OVF"}, 32'(OVF), 32'(ref_ovf(a, b)));
`endif
      @(negedge CLK);
      chk({tag, " idle hold"}, 32'({DONE, BUSY, BOUT, D}), 32'({2'b00, exp_bout, exp_d}));
   endtask

   initial begin
      vec_t tbl[$];
      logic [W-1:0] ra, rb;
      int gap, t_first;
      logic saw_done;

      tbl.push_back('{8'd100, 8'd37,  8'd63,  1'b0});
      tbl.push_back('{8'd37,  8'd100, 8'hC1,  1'b1});
      tbl.push_back('{8'd0,   8'd1,   8'd255, 1'b1});
      tbl.push_back('{8'd0,   8'd0,   8'd0,   1'b0});
      tbl.push_back('{8'd255, 8'd0,   8'd255, 1'b0});
      tbl.push_back('{8'd0,   8'd255, 8'd1,   1'b1});
      tbl.push_back('{8'hAA,  8'hAA,  8'd0,   1'b0});
      tbl.push_back('{8'h7F,  8'hFF,  8'h80,  1'b1});
      tbl.push_back('{8'h80,  8'h01,  8'h7F,  1'b0});

      // Reset state before any clock edge.
      #2;
      chk("reset outputs", 32'({BUSY, DONE, BOUT, D}), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      foreach (tbl[i]) run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp_d, tbl[i].exp_bout);

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op($sformatf("rnd%0d", i), ra, rb, ref_d(ra, rb), ref_bout(ra, rb));
      end

      // START re-pulsed and operands changed mid-operation: must be ignored.
      @(negedge CLK);
      A = 8'd100; B = 8'd37; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      A = 8'd0; B = 8'd255; START = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      START = 1'b0; A = 8'd1; B = 8'd2;
      saw_done = 1'b0;
      for (int i = 0; i < 20 && !saw_done; i++) begin
         @(negedge CLK);
         if (DONE) saw_done = 1'b1;
      end
      chk("ignore done seen", 32'(saw_done), 32'd1);
      chk("ignore D", 32'({BOUT, D}), 32'({1'b0, 8'd63}));
      @(negedge CLK);
      chk("ignore no restart", 32'(BUSY), 32'd0);

      // START held high: back-to-back operations every W+2 cycles.
      A = 8'd9; B = 8'd4; START = 1'b1;
      t_first = -1; gap = -1;
      for (int c = 0; c < 40 && gap < 0; c++) begin
         @(negedge CLK);
         if (DONE) begin
            if (t_first < 0) t_first = c;
            else             gap = c - t_first;
         end
      end
      chk("held start period", 32'(gap), 32'(W + 2));
      chk("held start D", 32'({BOUT, D}), 32'({1'b0, 8'd5}));
      START = 1'b0;
      for (int c = 0; c < 20 && (BUSY || DONE); c++) @(negedge CLK);
      chk("held start drained", 32'({BUSY, DONE}), 32'd0);

      // Asynchronous abort just after edge 4 of an operation.
      @(negedge CLK);
      A = 8'd200; B = 8'd17; START = 1'b1;
      @(posedge CLK);               // edge 0
      #1 START = 1'b0;
      repeat (4) @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      chk("abort outputs", 32'({BUSY, DONE, BOUT, D}), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge CLK);
         if (DONE || BUSY) saw_done = 1'b1;
      end
      chk("abort no done", 32'(saw_done), 32'd0);
      run_op("post abort", 8'd5, 8'd3, 8'd2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
